fp_divider: RTL and testbench
=============================

Name: fp_divider

Overview:
- IEEE-754 single-precision divider computing z = a / b.
- Sits beside the single-precision multiplier in the floating-point arithmetic library and uses the same three-port stb/ack stream handshake, so both units are drop-in interchangeable in operator pipelines.
- Multi-cycle, one operation in flight, restoring long division, round-to-nearest-even, denormals fully supported.

Parameters:
- DIV_ITERS, 50, quotient bits produced by long division. Fixed for single precision; not to be overridden.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- input_a  input  32  dividend, IEEE single
- input_a_stb  input  1  dividend valid
- input_a_ack  output  1  dividend accepted
- input_b  input  32  divisor, IEEE single
- input_b_stb  input  1  divisor valid
- input_b_ack  output  1  divisor accepted
- output_z  output  32  quotient, IEEE single
- output_z_stb  output  1  quotient valid
- output_z_ack  input  1  quotient consumed

Behaviour:
- Reset: clock clk; reset rst, synchronous, active-high. Reset has priority over every state action.
- Values after reset: state = get_a; input_a_ack, input_b_ack and output_z_stb = 0; output_z = 0.
- Reset mid-operation abandons the operation with no output. The next accepted operand is a fresh dividend.
- Handshake:
  - get_a drives ack=1. Transfer occurs on the cycle ack && stb are both high; ack drops the next cycle.
  - get_b behaves the same way, and runs strictly after a.
  - put_z holds stb=1 and output_z stable until output_z_ack is seen with stb high, then returns to get_a.
  - Minimum gap is 1 cycle for ack to rise before each transfer.
- States, in order: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, divide_3, normalise_1, normalise_2, round, pack, put_z.
- unpack:
  - Mantissa is 24 bits with bit 23 clear.
  - Exponent is 10-bit signed, equal to the raw exponent minus 127.
- special_cases (first match wins). NaN is always 0xFFC00000; all other results take sign a_s^b_s.
  - a or b NaN -> NaN.
  - a inf and b inf -> NaN.
  - a inf -> inf.
  - b inf -> zero.
  - b zero -> NaN if a is zero, else inf.
  - a zero -> zero.
  - Otherwise: a denormal sets exponent to -126, a normal sets mantissa bit 23; same for b. Go to normalise_a.
  - All special results go directly to put_z.
- normalise_a / normalise_b: while mantissa bit 23 is 0, shift left 1 and decrement the exponent, one bit per cycle.
- divide_0:
  - z_s = a_s^b_s; z_e = a_e - b_e.
  - dividend (51b) = a_m << 27; divisor (51b) = b_m; quotient = 0; remainder = 0; count = 0.
- divide_1 / divide_2 loop:
  - Shift quotient and remainder left 1; remainder[0] = dividend[50]; dividend <<= 1.
  - If remainder >= divisor: quotient[0] = 1 and remainder -= divisor.
  - Repeat DIV_ITERS times, then go to divide_3.
- divide_3:
  - z_m = quotient[26:3]; guard = quotient[2]; round_bit = quotient[1].
  - sticky = quotient[0] | (remainder != 0).
- normalise_1: while z_m[23] == 0, shift left pulling in guard, guard <= round_bit, round_bit <= 0, z_e -= 1.
- normalise_2: while z_e < -126, shift right, z_e += 1, guard <= z_m[0], round_bit <= guard, sticky |= round_bit.
- round:
  - If guard && (round_bit | sticky | z_m[0]), increment z_m.
  - If z_m was 0xFFFFFF, also increment z_e.
- pack:
  - Exponent field = z_e[7:0] + 127, forced to 0 if z_e == -126 and z_m[23] == 0.
  - If z_e > 127: exponent field 255, mantissa 0 (signed inf).
- Latency: about 110 cycles for normal operands, from divisor accept to output_z_stb rising. Extra cycles for denormal normalisation and underflow shifts. Throughput is one result per operation; no overlap.

Decomposition:
- Shared package fp_pkg holds:
  - the state enum;
  - constants FP_NAN = 32'hFFC00000, FP_EXP_BIAS = 127, FP_EMIN = -126, FP_EMAX = 127;
  - the typedef for unpacked {sign, 10-bit signed exp, 24-bit mantissa}.
- The multiplier migrates to fp_pkg as well.
- One sub-module is natural: fp_round_pack, the round-plus-pack logic shared with the multiplier.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000; 1 cycle each of stb/ack overlap per operand.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, checks round-to-nearest-even. 0xBF800000 / 0x40400000 -> 0xBEAAAAAB.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0x00000000 / 0x00000000 -> 0xFFC00000.
  - 0x7F800000 / 0x7F800000 -> 0xFFC00000.
  - 0x40000000 / 0xFF800000 -> 0x80000000.
- Range:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 -> 0x00400000 (denormal result).
  - 0x00000001 / 0x3F000000 -> 0x00000002 (denormal input).
- Backpressure: hold output_z_ack low 20 cycles -> output_z_stb stays 1, output_z constant. The next input_a_ack rises only after the ack is taken.
- Assert rst during divide_1 -> next cycle all acks and stb are 0. A following 6.0/2.0 yields 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: controller states, IEEE single
// constants and the internal unpacked operand format.
package fp_pkg;

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, DIVIDE_3, NORMALISE_1, NORMALISE_2,
    ROUND, PACK, PUT_Z
  } fp_state_t;

  localparam logic [31:0]        FP_NAN      = 32'hFFC00000;
  localparam logic signed [9:0]  FP_EXP_BIAS = 10'sd127;
  localparam logic signed [9:0]  FP_EMIN     = -10'sd126;
  localparam logic signed [9:0]  FP_EMAX     = 10'sd127;

  // Sign, unbiased exponent (wide enough for pre-normalisation excursions)
  // and 24-bit mantissa with the hidden bit made explicit.
  typedef struct packed {
    logic              s;
    logic signed [9:0] e;
    logic [23:0]       m;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and IEEE single packing, shared by the
// floating-point operators. Purely combinational.
module fp_round_pack
  import fp_pkg::*;
(
  input  fp_unpacked_t z_i,
  input  logic         guard_i,
  input  logic         round_bit_i,
  input  logic         sticky_i,
  output fp_unpacked_t rounded_o,
  output logic [31:0]  packed_o
);

  // Round up on more-than-half, or exactly half with an odd mantissa.
  always_comb begin
    rounded_o = z_i;
    if (guard_i && (round_bit_i || sticky_i || z_i.m[0])) begin
      rounded_o.m = z_i.m + 24'd1;
      // Mantissa wrapped to zero: the value is now 1.0 * 2^(e+1).
      if (z_i.m == 24'hFFFFFF) rounded_o.e = z_i.e + 10'sd1;
    end
  end

  // Bias the exponent, flag denormals via a zero field, saturate to inf.
  always_comb begin
    packed_o = {z_i.s, z_i.e[7:0] + 8'(FP_EXP_BIAS), z_i.m[22:0]};
    if ((z_i.e == FP_EMIN) && !z_i.m[23]) packed_o[30:23] = 8'd0;
    if ($signed(z_i.e) > FP_EMAX) packed_o[30:0] = {8'hFF, 23'd0};
  end

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, z = a / b. One operation in flight,
// restoring long division one quotient bit per two cycles, full denormal
// support, round-to-nearest-even. stb/ack handshake on all three ports.
module fp_divider
  import fp_pkg::*;
#(
  parameter int DIV_ITERS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  fp_state_t    state_q, state_d;
  logic         a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic [31:0]  z_out_q, z_out_d;
  logic [31:0]  a_q, a_d, b_q, b_d;
  fp_unpacked_t ua_q, ua_d, ub_q, ub_d, z_q, z_d;
  logic         guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
  logic [26:0]  quotient_q, quotient_d;
  logic [50:0]  remainder_q, remainder_d, dividend_q, dividend_d, divisor_q, divisor_d;
  logic [5:0]   count_q, count_d;
  fp_unpacked_t z_rounded;
  logic [31:0]  z_packed;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, z_sign;

  assign a_nan  = (ua_q.e == 10'sd128) && (ua_q.m != 24'd0);
  assign b_nan  = (ub_q.e == 10'sd128) && (ub_q.m != 24'd0);
  assign a_inf  = (ua_q.e == 10'sd128) && (ua_q.m == 24'd0);
  assign b_inf  = (ub_q.e == 10'sd128) && (ub_q.m == 24'd0);
  assign a_zero = (ua_q.e == -10'sd127) && (ua_q.m == 24'd0);
  assign b_zero = (ub_q.e == -10'sd127) && (ub_q.m == 24'd0);
  assign z_sign = ua_q.s ^ ub_q.s;

  fp_round_pack u_round_pack (
    .z_i        (z_q),
    .guard_i    (guard_q),
    .round_bit_i(round_bit_q),
    .sticky_i   (sticky_q),
    .rounded_o  (z_rounded),
    .packed_o   (z_packed)
  );

  // Next-state and datapath updates for every controller state.
  always_comb begin
    state_d = state_q;  a_ack_d = a_ack_q;  b_ack_d = b_ack_q;
    z_stb_d = z_stb_q;  z_out_d = z_out_q;
    a_d = a_q;  b_d = b_q;  ua_d = ua_q;  ub_d = ub_q;  z_d = z_q;
    guard_d = guard_q;  round_bit_d = round_bit_q;  sticky_d = sticky_q;
    quotient_d = quotient_q;  remainder_d = remainder_q;
    dividend_d = dividend_q;  divisor_d = divisor_q;  count_d = count_q;
    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d = input_a;  a_ack_d = 1'b0;  state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d = input_b;  b_ack_d = 1'b0;  state_d = UNPACK;
        end
      end
      UNPACK: begin
        ua_d.s = a_q[31];
        ua_d.e = $signed({2'b00, a_q[30:23]}) - FP_EXP_BIAS;
        ua_d.m = {1'b0, a_q[22:0]};
        ub_d.s = b_q[31];
        ub_d.e = $signed({2'b00, b_q[30:23]}) - FP_EXP_BIAS;
        ub_d.m = {1'b0, b_q[22:0]};
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf)) z_out_d = FP_NAN;
        else if (a_inf)  z_out_d = {z_sign, 8'hFF, 23'd0};
        else if (b_inf)  z_out_d = {z_sign, 31'd0};
        else if (b_zero) z_out_d = a_zero ? FP_NAN : {z_sign, 8'hFF, 23'd0};
        else if (a_zero) z_out_d = {z_sign, 31'd0};
        else begin
          // Denormals live at the minimum exponent without a hidden bit.
          if (ua_q.e == -10'sd127) ua_d.e = FP_EMIN; else ua_d.m[23] = 1'b1;
          if (ub_q.e == -10'sd127) ub_d.e = FP_EMIN; else ub_d.m[23] = 1'b1;
          state_d = NORMALISE_A;
        end
      end
      NORMALISE_A: begin
        if (ua_q.m[23]) state_d = NORMALISE_B;
        else begin
          ua_d.m = ua_q.m << 1;  ua_d.e = ua_q.e - 10'sd1;
        end
      end
      NORMALISE_B: begin
        if (ub_q.m[23]) state_d = DIVIDE_0;
        else begin
          ub_d.m = ub_q.m << 1;  ub_d.e = ub_q.e - 10'sd1;
        end
      end
      DIVIDE_0: begin
        z_d.s = z_sign;  z_d.e = ua_q.e - ub_q.e;
        dividend_d = {ua_q.m, 27'd0};  divisor_d = {27'd0, ub_q.m};
        quotient_d = '0;  remainder_d = '0;  count_d = '0;
        state_d = DIVIDE_1;
      end
      DIVIDE_1: begin
        quotient_d  = quotient_q << 1;
        remainder_d = {remainder_q[49:0], dividend_q[50]};
        dividend_d  = dividend_q << 1;
        state_d = DIVIDE_2;
      end
      DIVIDE_2: begin
        if (remainder_q >= divisor_q) begin
          quotient_d[0] = 1'b1;  remainder_d = remainder_q - divisor_q;
        end
        if (count_q == 6'(DIV_ITERS - 1)) state_d = DIVIDE_3;
        else begin
          count_d = count_q + 6'd1;  state_d = DIVIDE_1;
        end
      end
      DIVIDE_3: begin
        z_d.m = quotient_q[26:3];  guard_d = quotient_q[2];  round_bit_d = quotient_q[1];
        sticky_d = quotient_q[0] | (remainder_q != 51'd0);
        state_d = NORMALISE_1;
      end
      NORMALISE_1: begin
        if (!z_q.m[23]) begin
          z_d.m = {z_q.m[22:0], guard_q};  guard_d = round_bit_q;  round_bit_d = 1'b0;
          z_d.e = z_q.e - 10'sd1;
        end else state_d = NORMALISE_2;
      end
      NORMALISE_2: begin
        // Underflow: denormalise, folding shifted-out bits into the sticky.
        if ($signed(z_q.e) < FP_EMIN) begin
          z_d.e = z_q.e + 10'sd1;  z_d.m = z_q.m >> 1;
          guard_d = z_q.m[0];  round_bit_d = guard_q;  sticky_d = sticky_q | round_bit_q;
        end else state_d = ROUND;
      end
      ROUND: begin
        z_d = z_rounded;  state_d = PACK;
      end
      PACK: begin
        z_out_d = z_packed;  state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = 1'b1;
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;  state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // Control and visible outputs: reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;  a_ack_q <= 1'b0;  b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;   z_out_q <= 32'd0;
    end else begin
      state_q <= state_d;  a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;  z_out_q <= z_out_d;
    end
  end

  // Datapath registers: always rewritten before use, so never reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;  b_q <= b_d;  ua_q <= ua_d;  ub_q <= ub_d;  z_q <= z_d;
    guard_q <= guard_d;  round_bit_q <= round_bit_d;  sticky_q <= sticky_d;
    quotient_q <= quotient_d;  remainder_q <= remainder_d;
    dividend_q <= dividend_d;  divisor_q <= divisor_d;  count_q <= count_d;
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_out_q;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed corner cases, backpressure and reset
// abandonment, then random operands against an exact-arithmetic model.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'd0, input_b = 32'd0;
  logic        input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
  logic        input_a_ack, input_b_ack, output_z_stb;
  logic [31:0] output_z;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .input_b     (input_b),
    .input_b_stb (input_b_stb),
    .input_b_ack (input_b_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Exact quotient: value = sig * 2^exp, divide with integers, then round
  // the result to nearest-even at its IEEE precision (24 bits or denormal).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   sz, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, half;
    int     ea, eb, e, msb, lsb, sh;
    longint ma, mb, q, r, qq, m, low;
    sz     = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf)) return 32'hFFC00000;
    if (a_inf) return {sz, 8'hFF, 23'd0};
    if (b_inf) return {sz, 31'd0};
    if (b_zero) return a_zero ? 32'hFFC00000 : {sz, 8'hFF, 23'd0};
    if (a_zero) return {sz, 31'd0};
    ma = a[22:0];  ea = -149;
    if (a[30:23] != 0) begin ma = ma | (1 << 23); ea = int'(a[30:23]) - 150; end
    mb = b[22:0];  eb = -149;
    if (b[30:23] != 0) begin mb = mb | (1 << 23); eb = int'(b[30:23]) - 150; end
    while (ma < (1 << 23)) begin ma = ma << 1; ea--; end
    while (mb < (1 << 23)) begin mb = mb << 1; eb--; end
    q  = (ma << 26) / mb;
    r  = (ma << 26) % mb;
    qq = (q << 1) | longint'(r != 0);   // trailing sticky bit
    e  = ea - eb - 27;                  // value = qq * 2^e
    msb = 0;
    for (int i = 0; i < 40; i++) if (qq[i]) msb = i;
    lsb = e + msb - 23;
    if (lsb < -149) lsb = -149;
    sh = lsb - e;
    if (sh > 40) sh = 40;
    m    = qq >> sh;
    half = qq[sh-1];
    low  = qq & ((64'd1 << (sh - 1)) - 1);
    if (half && (low != 0 || m[0])) m++;
    if (m == (1 << 24)) begin m = m >> 1; lsb++; end
    if (m < (1 << 23)) return {sz, 8'd0, m[22:0]};
    if (lsb + 150 >= 255) return {sz, 8'hFF, 23'd0};
    return {sz, 8'(lsb + 150), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: begin v[30:23] = 8'd0; if ($urandom_range(0, 3) == 0) v[22:0] = 23'd0; end
      1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0; end
      2: v[30:23] = 8'($urandom_range(1, 4));
      3: v[30:23] = 8'($urandom_range(250, 254));
      4: v[22:0] = 23'd0;
      default: v[30:23] = 8'($urandom_range(110, 144));
    endcase
    return v;
  endfunction

  // Present both operands; each stb overlaps its ack for one cycle.
  task automatic send_operands(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    input_a = a;  input_a_stb = 1'b1;  n = 0;
    while (!input_a_ack && n < 50) begin @(negedge clk); n++; end
    if (!input_a_ack) check_val("a_ack_timeout", 32'(input_a_ack), 32'd1);
    @(negedge clk);
    input_a_stb = 1'b0;
    input_b = b;  input_b_stb = 1'b1;  n = 0;
    while (!input_b_ack && n < 50) begin @(negedge clk); n++; end
    if (!input_b_ack) check_val("b_ack_timeout", 32'(input_b_ack), 32'd1);
    @(negedge clk);
    input_b_stb = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] z);
    int n;
    logic [31:0] held;
    send_operands(a, b);
    n = 0;
    while (!output_z_stb && n < 600) begin @(negedge clk); n++; end
    z = output_z;
    if (!output_z_stb) begin
      check_val("z_stb_timeout", 32'(output_z_stb), 32'd1);
      return;
    end
    held = output_z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_stb", 32'(output_z_stb), 32'd1);
      check_val("hold_z", output_z, held);
      check_val("hold_a_ack", 32'(input_a_ack), 32'd0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    if (hold > 0) begin
      check_val("stb_drop", 32'(output_z_stb), 32'd0);
      check_val("a_ack_after_take", 32'(input_a_ack), 32'd0);
      @(negedge clk);
      check_val("a_ack_rise", 32'(input_a_ack), 32'd1);
    end
  endtask

  logic [31:0] dir_a [13] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                              32'h00000000, 32'h7F800000, 32'h40000000, 32'h7F7FFFFF,
                              32'h00800000, 32'h00000001, 32'h7FC00000, 32'h80000000,
                              32'h00000000};
  logic [31:0] dir_b [13] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                              32'h00000000, 32'h7F800000, 32'hFF800000, 32'h3F000000,
                              32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000};
  logic [31:0] dir_z [13] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000,
                              32'hFFC00000, 32'hFFC00000, 32'h80000000, 32'h7F800000,
                              32'h00400000, 32'h00000002, 32'hFFC00000, 32'h80000000,
                              32'h00000000};

  initial begin
    logic [31:0] z, a, b;
    repeat (3) @(negedge clk);
    check_val("rst_a_ack", 32'(input_a_ack), 32'd0);
    check_val("rst_b_ack", 32'(input_b_ack), 32'd0);
    check_val("rst_z_stb", 32'(output_z_stb), 32'd0);
    check_val("rst_z", output_z, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(dir_a[i], dir_b[i], 0, z);
      check_val($sformatf("dir%0d %h/%h", i, dir_a[i], dir_b[i]), z, dir_z[i]);
    end

    run_op(32'h40C00000, 32'h40000000, 20, z);
    check_val("backpressure_z", z, 32'h40400000);

    send_operands(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_a_ack", 32'(input_a_ack), 32'd0);
    check_val("midrst_b_ack", 32'(input_b_ack), 32'd0);
    check_val("midrst_z_stb", 32'(output_z_stb), 32'd0);
    check_val("midrst_z", output_z, 32'd0);
    run_op(32'h40C00000, 32'h40000000, 0, z);
    check_val("after_rst_z", z, 32'h40400000);

    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      run_op(a, b, int'($urandom_range(0, 2)), z);
      check_val($sformatf("rand %h/%h", a, b), z, ref_div(a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
